// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the data bus fabric
// Holds the access FSM state enum, fault cause bit positions, fault register
// offsets and the default base address of the fault register window.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bus_state_e;

  // Fault cause register bit positions
  localparam int CAUSE_W        = 3;
  localparam int CAUSE_UNMAPPED = 0;
  localparam int CAUSE_TIMEOUT  = 1;
  localparam int CAUSE_OVERRUN  = 2;

  // Byte offsets inside the 8-byte fault register window
  localparam logic [2:0] OFF_FAULT_ADDR  = 3'd0;
  localparam logic [2:0] OFF_FAULT_CAUSE = 3'd4;

  localparam logic [31:0] DEFAULT_FAULT_BASE = 32'hFFFF_FFF0;

endpackage

// File: rtl/data_bus_fabric_if.sv
// rtl/data_bus_fabric_if.sv - master-side and slave-side bus signals of the fabric
// Ports (signals): m_req/m_addr/m_wdata/m_wstrb from the CPU data port,
// m_ready/m_rdata/m_err back to it; s_req/s_addr/s_wdata/s_wstrb to the
// peripherals, s_ready/s_rdata from them; fault_irq to the PLIC.
// Modport slave is the fabric's view, modport master the surrounding system's.
interface data_bus_fabric_if #(
  parameter int SLAVES = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic                     m_req;
  logic [ADDR_W-1:0]        m_addr;
  logic [DATA_W-1:0]        m_wdata;
  logic [STRB_W-1:0]        m_wstrb;
  logic                     m_ready;
  logic [DATA_W-1:0]        m_rdata;
  logic                     m_err;
  logic [SLAVES-1:0]        s_req;
  logic [ADDR_W-1:0]        s_addr;
  logic [DATA_W-1:0]        s_wdata;
  logic [STRB_W-1:0]        s_wstrb;
  logic [SLAVES-1:0]        s_ready;
  logic [SLAVES*DATA_W-1:0] s_rdata;
  logic                     fault_irq;

  modport slave (
    input  m_req, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    output m_ready, m_rdata, m_err, s_req, s_addr, s_wdata, s_wstrb, fault_irq
  );

  modport master (
    output m_req, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    input  m_ready, m_rdata, m_err, s_req, s_addr, s_wdata, s_wstrb, fault_irq
  );

endinterface

// File: rtl/bus_addr_decoder.sv
// rtl/bus_addr_decoder.sv - base/mask slave window match with priority encode
// Ports: m_addr (in) address to decode; hit (out) some slot matched;
// sel (out) lowest matching slot index; fault_hit (out) address lies in the
// 8-byte fault register window, which outranks every slot.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int                     SLAVES     = 8,
  parameter int                     ADDR_W     = 32,
  parameter int                     SEL_W      = 3,
  parameter logic [SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [SLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
  parameter logic [ADDR_W-1:0]      FAULT_BASE = ADDR_W'(DEFAULT_FAULT_BASE)
) (
  input  logic [ADDR_W-1:0] m_addr,
  output logic              hit,
  output logic [SEL_W-1:0]  sel,
  output logic              fault_hit
);

  // Walk from the top slot down so the lowest matching index is the last write
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLAVE_BASE[i*ADDR_W +: ADDR_W] & SLAVE_MASK[i*ADDR_W +: ADDR_W])) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end

  assign fault_hit = (m_addr[ADDR_W-1:3] == FAULT_BASE[ADDR_W-1:3]);

endmodule

// File: rtl/data_bus_fabric.sv
// rtl/data_bus_fabric.sv - data-side bus fabric with slave windows, wait states, watchdog and fault record
// Ports: sys_clk system clock; rst asynchronous active-high reset;
// bus (slave modport) carries the CPU request/response and the shared
// peripheral request bus plus the fault interrupt line.
module data_bus_fabric
  import bus_pkg::*;
#(
  parameter int                       SLAVES     = 8,
  parameter int                       ADDR_W     = 32,
  parameter int                       DATA_W     = 32,
  parameter logic [SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [SLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
  parameter logic [ADDR_W-1:0]        FAULT_BASE = ADDR_W'(DEFAULT_FAULT_BASE),
  parameter int                       TIMEOUT    = 255
) (
  input  logic           sys_clk,
  input  logic           rst,
  data_bus_fabric_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W  = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int CNT_W  = (TIMEOUT >= 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  bus_state_e         state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SLAVES-1:0]  s_req_q, s_req_d;
  logic [ADDR_W-1:0]  s_addr_q, s_addr_d;
  logic [DATA_W-1:0]  s_wdata_q, s_wdata_d;
  logic [STRB_W-1:0]  s_wstrb_q, s_wstrb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  m_rdata_q, m_rdata_d;
  logic               m_err_q, m_err_d;
  logic [ADDR_W-1:0]  f_addr_q, f_addr_d;
  logic [CAUSE_W-1:0] f_cause_q, f_cause_d;
  logic               fault_irq_q;

  logic               dec_hit, dec_fault_hit;
  logic [SEL_W-1:0]   dec_sel;
  logic               fault_now;
  logic [CAUSE_W-1:0] fault_bit;
  logic [ADDR_W-1:0]  fault_at;

  bus_addr_decoder #(
    .SLAVES     (SLAVES),
    .ADDR_W     (ADDR_W),
    .SEL_W      (SEL_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK),
    .FAULT_BASE (FAULT_BASE)
  ) u_dec (
    .m_addr    (bus.m_addr),
    .hit       (dec_hit),
    .sel       (dec_sel),
    .fault_hit (dec_fault_hit)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    s_req_d   = s_req_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wstrb_d = s_wstrb_q;
    cnt_d     = cnt_q;
    m_rdata_d = '0;
    m_err_d   = 1'b0;
    f_addr_d  = f_addr_q;
    f_cause_d = f_cause_q;
    fault_now = 1'b0;
    fault_bit = '0;
    fault_at  = '0;

    case (state_q)
      IDLE: begin
        if (bus.m_req) begin
          if (dec_fault_hit) begin
            state_d = RESP;
            if (bus.m_wstrb == '0) begin
              if (bus.m_addr[2:0] == OFF_FAULT_ADDR) begin
                m_rdata_d = DATA_W'(f_addr_q);
              end else if (bus.m_addr[2:0] == OFF_FAULT_CAUSE) begin
                m_rdata_d = DATA_W'(f_cause_q);
              end
            end else if (bus.m_addr[2:0] == OFF_FAULT_CAUSE) begin
              f_addr_d  = '0;
              f_cause_d = '0;
            end
          end else if (dec_hit) begin
            state_d          = ACCESS;
            sel_d            = dec_sel;
            s_req_d          = '0;
            s_req_d[dec_sel] = 1'b1;
            s_addr_d         = bus.m_addr;
            s_wdata_d        = bus.m_wdata;
            s_wstrb_d        = bus.m_wstrb;
            cnt_d            = '0;
          end else begin
            state_d                   = RESP;
            m_err_d                   = 1'b1;
            fault_now                 = 1'b1;
            fault_bit[CAUSE_UNMAPPED] = 1'b1;
            fault_at                  = bus.m_addr;
          end
        end
      end
      ACCESS: begin
        // A ready on the same cycle the count hits the limit still completes cleanly
        if (bus.s_ready[sel_q]) begin
          state_d   = RESP;
          s_req_d   = '0;
          m_rdata_d = bus.s_rdata[int'(sel_q)*DATA_W +: DATA_W];
        end else if (TIMEOUT != 0 && cnt_q == TIMEOUT_C) begin
          state_d                  = RESP;
          s_req_d                  = '0;
          m_err_d                  = 1'b1;
          fault_now                = 1'b1;
          fault_bit[CAUSE_TIMEOUT] = 1'b1;
          fault_at                 = s_addr_q;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // First fault owns the address; later ones only accumulate cause bits
    if (fault_now) begin
      if (f_cause_q == '0) begin
        f_addr_d  = fault_at;
        f_cause_d = fault_bit;
      end else begin
        f_cause_d                = f_cause_q | fault_bit;
        f_cause_d[CAUSE_OVERRUN] = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      s_req_q     <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_wstrb_q   <= '0;
      cnt_q       <= '0;
      m_rdata_q   <= '0;
      m_err_q     <= 1'b0;
      f_addr_q    <= '0;
      f_cause_q   <= '0;
      fault_irq_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      s_req_q     <= s_req_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_wstrb_q   <= s_wstrb_d;
      cnt_q       <= cnt_d;
      m_rdata_q   <= m_rdata_d;
      m_err_q     <= m_err_d;
      f_addr_q    <= f_addr_d;
      f_cause_q   <= f_cause_d;
      fault_irq_q <= |f_cause_q;
    end
  end

  assign bus.m_ready   = (state_q == RESP);
  assign bus.m_rdata   = m_rdata_q;
  assign bus.m_err     = m_err_q;
  assign bus.s_req     = s_req_q;
  assign bus.s_addr    = s_addr_q;
  assign bus.s_wdata   = s_wdata_q;
  assign bus.s_wstrb   = s_wstrb_q;
  assign bus.fault_irq = fault_irq_q;

endmodule

// File: tb/tb_data_bus_fabric.sv
// tb/tb_data_bus_fabric.sv - directed self-checking bench for data_bus_fabric
module tb_data_bus_fabric;

  localparam int SLAVES  = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;
  // slot3 .. slot0
  localparam logic [SLAVES*ADDR_W-1:0] BASES =
    {32'h4000_0000, 32'h8000_0000, 32'h4000_0000, 32'h1000_0000};
  localparam logic [SLAVES*ADDR_W-1:0] MASKS =
    {32'hF000_0000, 32'hC000_0000, 32'hFFFF_0000, 32'hF000_0000};

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 sys_clk = ~sys_clk;

  data_bus_fabric_if #(.SLAVES(SLAVES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  data_bus_fabric #(
    .SLAVES     (SLAVES),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .SLAVE_BASE (BASES),
    .SLAVE_MASK (MASKS),
    .FAULT_BASE (32'hFFFF_FFF0),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus_if)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Drives one request; returns cycles from accept edge to m_ready (-1 if none)
  task automatic run_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input int rdy_slot,
                            input int rdy_cycle, input logic [31:0] rdy_data,
                            output int lat, output logic err, output logic [31:0] rd);
    lat = -1;
    err = 1'bx;
    rd  = 'x;
    bus_if.m_req   = 1'b1;
    bus_if.m_addr  = addr;
    bus_if.m_wdata = wdata;
    bus_if.m_wstrb = wstrb;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus_if.m_ready) begin
        lat = c;
        err = bus_if.m_err;
        rd  = bus_if.m_rdata;
        break;
      end
      bus_if.s_ready = '0;
      if (c == rdy_cycle && rdy_slot >= 0) begin
        bus_if.s_ready[rdy_slot] = 1'b1;
        bus_if.s_rdata[rdy_slot*DATA_W +: DATA_W] = rdy_data;
      end
    end
    bus_if.m_req   = 1'b0;
    bus_if.m_wstrb = '0;
    bus_if.s_ready = '0;
    tick();
  endtask

  task automatic test_reset();
    int lat;
    logic err;
    logic [31:0] rd;
    bus_if.m_req   = 1'b0;
    bus_if.m_addr  = '0;
    bus_if.m_wdata = '0;
    bus_if.m_wstrb = '0;
    bus_if.s_ready = '0;
    bus_if.s_rdata = '0;
    tick();
    tick();
    checks++; if (bus_if.m_ready !== 1'b0) begin failures++; $display("FAIL reset_m_ready got=%b exp=0", bus_if.m_ready); end
    checks++; if (bus_if.m_err !== 1'b0) begin failures++; $display("FAIL reset_m_err got=%b exp=0", bus_if.m_err); end
    checks++; if (bus_if.m_rdata !== 32'h0) begin failures++; $display("FAIL reset_m_rdata got=%h exp=0", bus_if.m_rdata); end
    checks++; if (bus_if.s_req !== 4'h0) begin failures++; $display("FAIL reset_s_req got=%b exp=0000", bus_if.s_req); end
    checks++; if (bus_if.s_addr !== 32'h0) begin failures++; $display("FAIL reset_s_addr got=%h exp=0", bus_if.s_addr); end
    checks++; if (bus_if.s_wdata !== 32'h0) begin failures++; $display("FAIL reset_s_wdata got=%h exp=0", bus_if.s_wdata); end
    checks++; if (bus_if.s_wstrb !== 4'h0) begin failures++; $display("FAIL reset_s_wstrb got=%h exp=0", bus_if.s_wstrb); end
    checks++; if (bus_if.fault_irq !== 1'b0) begin failures++; $display("FAIL reset_fault_irq got=%b exp=0", bus_if.fault_irq); end
    rst = 1'b0;
    tick();
    run_access(32'hFFFF_FFF0, 32'h0, 4'h0, -1, 0, 32'h0, lat, err, rd);
    checks++; if (lat !== 1 || err !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL reset_fault_addr got lat=%0d err=%b rd=%h exp lat=1 err=0 rd=0", lat, err, rd); end
    run_access(32'hFFFF_FFF4, 32'h0, 4'h0, -1, 0, 32'h0, lat, err, rd);
    checks++; if (lat !== 1 || err !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL reset_fault_cause got lat=%0d err=%b rd=%h exp lat=1 err=0 rd=0", lat, err, rd); end
  endtask

  task automatic test_slave_read();
    bus_if.m_req   = 1'b1;
    bus_if.m_addr  = 32'h8000_0010;
    bus_if.m_wdata = 32'h0BAD_0BAD;
    bus_if.m_wstrb = 4'h0;
    tick(); // T+1
    checks++; if (bus_if.s_req !== 4'b0100) begin failures++; $display("FAIL read_s_req got=%b exp=0100", bus_if.s_req); end
    checks++; if (bus_if.s_addr !== 32'h8000_0010) begin failures++; $display("FAIL read_s_addr got=%h exp=80000010", bus_if.s_addr); end
    checks++; if (bus_if.s_wstrb !== 4'h0) begin failures++; $display("FAIL read_s_wstrb got=%h exp=0", bus_if.s_wstrb); end
    // Non-selected slaves claim ready; must be ignored
    bus_if.s_ready = 4'b1011;
    bus_if.s_rdata = {32'h3333_3333, 32'h0, 32'h1111_1111, 32'h0000_0000};
    tick(); // T+2
    bus_if.s_ready = '0;
    checks++; if (bus_if.m_ready !== 1'b0 || bus_if.s_req !== 4'b0100) begin failures++; $display("FAIL read_ignore_other got m_ready=%b s_req=%b exp m_ready=0 s_req=0100", bus_if.m_ready, bus_if.s_req); end
    tick(); // T+3
    bus_if.s_ready[2] = 1'b1;
    bus_if.s_rdata[2*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    checks++; if (bus_if.m_ready !== 1'b0) begin failures++; $display("FAIL read_early_ready got=%b exp=0", bus_if.m_ready); end
    tick(); // T+4
    bus_if.s_ready = '0;
    checks++; if (bus_if.m_ready !== 1'b1) begin failures++; $display("FAIL read_m_ready_T4 got=%b exp=1", bus_if.m_ready); end
    checks++; if (bus_if.m_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_m_rdata got=%h exp=deadbeef", bus_if.m_rdata); end
    checks++; if (bus_if.m_err !== 1'b0 || bus_if.s_req !== 4'h0) begin failures++; $display("FAIL read_err_sreq got err=%b s_req=%b exp 0 0000", bus_if.m_err, bus_if.s_req); end
    bus_if.m_req = 1'b0;
    tick();
  endtask

  task automatic test_overlap();
    int lat;
    logic err;
    logic [31:0] rd;
    bus_if.m_req   = 1'b1;
    bus_if.m_addr  = 32'h4000_0000;
    bus_if.m_wdata = 32'h1234_5678;
    bus_if.m_wstrb = 4'h3;
    tick(); // T+1
    checks++; if (bus_if.s_req !== 4'b0010) begin failures++; $display("FAIL overlap_s_req got=%b exp=0010", bus_if.s_req); end
    checks++; if (bus_if.s_wdata !== 32'h1234_5678 || bus_if.s_wstrb !== 4'h3) begin failures++; $display("FAIL overlap_wdata got=%h/%h exp=12345678/3", bus_if.s_wdata, bus_if.s_wstrb); end
    bus_if.s_ready = 4'b1010;
    bus_if.s_rdata = {32'h0000_0003, 32'h0, 32'h0000_0001, 32'h0};
    tick(); // T+2: minimum latency
    bus_if.s_ready = '0;
    checks++; if (bus_if.m_ready !== 1'b1 || bus_if.m_err !== 1'b0) begin failures++; $display("FAIL overlap_min_latency got m_ready=%b err=%b exp 1 0", bus_if.m_ready, bus_if.m_err); end
    checks++; if (bus_if.m_rdata !== 32'h0000_0001) begin failures++; $display("FAIL overlap_rdata_sel got=%h exp=00000001", bus_if.m_rdata); end
    bus_if.m_req   = 1'b0;
    bus_if.m_wstrb = '0;
    tick();
    run_access(32'h4100_0000, 32'h0, 4'h0, 3, 1, 32'h3C3C_3C3C, lat, err, rd);
    checks++; if (lat !== 2 || err !== 1'b0 || rd !== 32'h3C3C_3C3C) begin failures++; $display("FAIL slot3_only got lat=%0d err=%b rd=%h exp lat=2 err=0 rd=3c3c3c3c", lat, err, rd); end
  endtask

  task automatic test_unmapped();
    int lat;
    logic err;
    logic [31:0] rd;
    bus_if.m_req   = 1'b1;
    bus_if.m_addr  = 32'h7000_0004;
    bus_if.m_wstrb = 4'h0;
    tick(); // T+1
    checks++; if (bus_if.m_ready !== 1'b1 || bus_if.m_err !== 1'b1 || bus_if.m_rdata !== 32'h0) begin failures++; $display("FAIL unmapped_resp got ready=%b err=%b rd=%h exp 1 1 0", bus_if.m_ready, bus_if.m_err, bus_if.m_rdata); end
    checks++; if (bus_if.s_req !== 4'h0) begin failures++; $display("FAIL unmapped_s_req got=%b exp=0000", bus_if.s_req); end
    bus_if.m_req = 1'b0;
    tick();
    checks++; if (bus_if.fault_irq !== 1'b1) begin failures++; $display("FAIL unmapped_irq got=%b exp=1", bus_if.fault_irq); end
    run_access(32'hFFFF_FFF0, 32'h0, 4'h0, -1, 0, 32'h0, lat, err, rd);
    checks++; if (lat !== 1 || err !== 1'b0 || rd !== 32'h7000_0004) begin failures++; $display("FAIL unmapped_fault_addr got lat=%0d err=%b rd=%h exp 1 0 70000004", lat, err, rd); end
    run_access(32'hFFFF_FFF4, 32'h0, 4'h0, -1, 0, 32'h0, lat, err, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL unmapped_cause got=%h exp=1", rd); end
  endtask

  task automatic test_clear();
    int lat;
    logic err;
    logic [31:0] rd;
    bus_if.m_req   = 1'b1;
    bus_if.m_addr  = 32'hFFFF_FFF4;
    bus_if.m_wdata = 32'h1;
    bus_if.m_wstrb = 4'hF;
    tick(); // T+1
    checks++; if (bus_if.m_ready !== 1'b1 || bus_if.m_err !== 1'b0 || bus_if.fault_irq !== 1'b1) begin failures++; $display("FAIL clear_resp got ready=%b err=%b irq=%b exp 1 0 1", bus_if.m_ready, bus_if.m_err, bus_if.fault_irq); end
    bus_if.m_req   = 1'b0;
    bus_if.m_wstrb = '0;
    tick(); // T+2
    checks++; if (bus_if.fault_irq !== 1'b0) begin failures++; $display("FAIL clear_irq_fall got=%b exp=0", bus_if.fault_irq); end
    run_access(32'hFFFF_FFF4, 32'h0, 4'h0, -1, 0, 32'h0, lat, err, rd);
    checks++; if (lat !== 1 || rd !== 32'h0) begin failures++; $display("FAIL clear_cause got lat=%0d rd=%h exp 1 0", lat, rd); end
  endtask

  task automatic test_timeout();
    int lat;
    logic err;
    logic [31:0] rd;
    logic ok;
    bus_if.m_req   = 1'b1;
    bus_if.m_addr  = 32'h1000_0020;
    bus_if.m_wstrb = 4'h0;
    tick(); // T+1
    checks++; if (bus_if.s_req !== 4'b0001) begin failures++; $display("FAIL timeout_s_req got=%b exp=0001", bus_if.s_req); end
    ok = 1'b1;
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (bus_if.s_req !== 4'b0001 || bus_if.m_ready !== 1'b0) ok = 1'b0;
    end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL timeout_wait got early completion exp waiting through T+5"); end
    tick(); // T+6
    checks++; if (bus_if.m_ready !== 1'b1 || bus_if.m_err !== 1'b1 || bus_if.m_rdata !== 32'h0) begin failures++; $display("FAIL timeout_resp_T6 got ready=%b err=%b rd=%h exp 1 1 0", bus_if.m_ready, bus_if.m_err, bus_if.m_rdata); end
    checks++; if (bus_if.s_req !== 4'h0) begin failures++; $display("FAIL timeout_s_req_drop got=%b exp=0000", bus_if.s_req); end
    bus_if.m_req = 1'b0;
    tick();
    run_access(32'hFFFF_FFF4, 32'h0, 4'h0, -1, 0, 32'h0, lat, err, rd);
    checks++; if (rd !== 32'h2) begin failures++; $display("FAIL timeout_cause got=%h exp=2", rd); end
    run_access(32'h7000_0008, 32'h0, 4'h0, -1, 0, 32'h0, lat, err, rd);
    checks++; if (lat !== 1 || err !== 1'b1) begin failures++; $display("FAIL overrun_resp got lat=%0d err=%b exp 1 1", lat, err); end
    run_access(32'hFFFF_FFF4, 32'h0, 4'h0, -1, 0, 32'h0, lat, err, rd);
    checks++; if (rd !== 32'h7) begin failures++; $display("FAIL overrun_cause got=%h exp=7", rd); end
    run_access(32'hFFFF_FFF0, 32'h0, 4'h0, -1, 0, 32'h0, lat, err, rd);
    checks++; if (rd !== 32'h1000_0020) begin failures++; $display("FAIL overrun_addr_kept got=%h exp=10000020", rd); end
    checks++; if (bus_if.fault_irq !== 1'b1) begin failures++; $display("FAIL overrun_irq got=%b exp=1", bus_if.fault_irq); end
    run_access(32'hFFFF_FFF4, 32'h0, 4'hF, -1, 0, 32'h0, lat, err, rd);
  endtask

  task automatic test_timeout_race();
    int lat;
    logic err;
    logic [31:0] rd;
    // Ready arrives on the cycle the count reaches TIMEOUT
    run_access(32'h1000_0040, 32'h0, 4'h0, 0, 5, 32'h5A5A_0001, lat, err, rd);
    checks++; if (lat !== 6 || err !== 1'b0 || rd !== 32'h5A5A_0001) begin failures++; $display("FAIL race_ready_wins got lat=%0d err=%b rd=%h exp 6 0 5a5a0001", lat, err, rd); end
    run_access(32'hFFFF_FFF4, 32'h0, 4'h0, -1, 0, 32'h0, lat, err, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL race_no_fault got=%h exp=0", rd); end
  endtask

  task automatic test_reset_mid_access();
    int lat;
    logic err;
    logic [31:0] rd;
    logic seen;
    bus_if.m_req   = 1'b1;
    bus_if.m_addr  = 32'h8000_0000;
    bus_if.m_wstrb = 4'h0;
    tick(); // T+1
    checks++; if (bus_if.s_req !== 4'b0100) begin failures++; $display("FAIL rst_mid_pre_s_req got=%b exp=0100", bus_if.s_req); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus_if.s_req !== 4'h0) begin failures++; $display("FAIL rst_mid_async_s_req got=%b exp=0000", bus_if.s_req); end
    bus_if.m_req = 1'b0;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus_if.m_ready !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_no_ready got=1 exp=0"); end
    run_access(32'h8000_0004, 32'h0, 4'h0, 2, 1, 32'hCAFE_F00D, lat, err, rd);
    checks++; if (lat !== 2 || err !== 1'b0 || rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL rst_mid_next got lat=%0d err=%b rd=%h exp 2 0 cafef00d", lat, err, rd); end
  endtask

  initial begin
    test_reset();
    test_slave_read();
    test_overlap();
    test_unmapped();
    test_clear();
    test_timeout();
    test_timeout_race();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
